mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-access port. Arbitrates and sequences each access over a fixed-latency memory, returning read data and a one-cycle acknowledge to the winning requester. Drives a pipeline-wide `stall` while any request is outstanding. Sits between the `mips` core (pc/inst and mem_addr/read_data/mem_write/write_data ports) and the memory model.

## Interface
- `WIDTH`, 32, address/data width
- `MEM_LATENCY`, 1, cycles from `mem_en` to valid `mem_rdata`; legal 1..15
- `STARVE_LIMIT`, 4, consecutive data grants tolerated while fetch waits; legal 1..15

- `clk` in 1, sole clock, rising edge
- `reset` in 1, asynchronous, active-high
- `if_req` in 1, fetch request
- `if_addr` in WIDTH, fetch address
- `if_rdata` out WIDTH, fetched word
- `if_ack` out 1, fetch complete pulse
- `d_req` in 1, data request
- `d_we` in 1, 1 = write
- `d_addr` in WIDTH, data address
- `d_wdata` in WIDTH, store data
- `d_rdata` out WIDTH, load data
- `d_ack` out 1, data complete pulse
- `stall` out 1, pipeline hold
- `mem_en` out 1, memory access strobe
- `mem_we` out 1, memory write enable
- `mem_addr` out WIDTH, memory address
- `mem_wdata` out WIDTH, memory write data
- `mem_rdata` in WIDTH, memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: at a clock edge with `if_req|d_req`, latch owner and register address/we/wdata; go ISSUE. Otherwise stay.
- Grant: data wins over fetch, except when the starvation guard forces fetch (see Configuration).
- ISSUE: `mem_en`=1 for exactly this cycle; `mem_we`=`d_we` for data owner, 0 for fetch. Load latency counter with `MEM_LATENCY`; go WAIT.
- WAIT: decrement the counter each cycle. On the cycle it reaches 0, capture `mem_rdata` into the owner's rdata register (reads only), then go DONE.
- DONE: owner's ack=1 for one cycle; no arbitration in DONE; next state IDLE.
- Writes follow identical sequencing. `d_rdata` holds its previous value.
- `if_rdata`/`d_rdata` hold their last captured value until the next read completes for that port.
- `stall` = (`if_req` & ~`if_ack`) | (`d_req` & ~`d_ack`), combinational.
- Requester contract: hold req/addr/we/wdata stable until ack. If req drops early, the access still completes and ack still pulses.
- Outside ISSUE: `mem_en`=0, `mem_we`=0. `mem_addr`/`mem_wdata` hold the last issued values.

## Timing
- Request sampled at edge T. ISSUE occupies cycle T+1. `mem_rdata` is captured at the end of cycle T+1+`MEM_LATENCY`. Ack is high in cycle T+2+`MEM_LATENCY`.
- Throughput: one access per `MEM_LATENCY`+3 cycles under back-to-back requests.
- Both requests at the same edge: one is granted; the other waits and is granted on the first IDLE edge after DONE.
- Reset values: state IDLE, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_rdata`=0, `d_rdata`=0, `if_ack`=0, `d_ack`=0, starvation count 0.
- Reset asserted mid-access: the access is abandoned and no ack is ever issued for it. After release, the FSM re-arbitrates from IDLE.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: a 4-bit counter tracks data grants.
  - Increments on each data grant made while `if_req`=1.
  - Clears on each fetch grant, and on any data grant made while `if_req`=0.
  - When count == `STARVE_LIMIT` and both requests are present, fetch is granted.
- Not defined: strict data priority. There is no counter and fetch can starve indefinitely.

## Test plan
- Single fetch, `MEM_LATENCY`=2, `if_addr`=0x40, memory returns 0x8C020004 -> `mem_en` high in cycle T+1, `if_ack` high in T+4, `if_rdata`=0x8C020004, `stall` low in T+5.
- `if_req` and `d_req` (load 0x100) asserted in the same cycle -> data granted first, `d_ack` at T+4; fetch issued at T+6, `if_ack` at T+9.
- Store `d_addr`=0x200, `d_wdata`=0xDEADBEEF -> one ISSUE cycle with `mem_we`=1, `mem_addr`=0x200; `d_ack` pulses; `d_rdata` unchanged.
- Guard on, `STARVE_LIMIT`=2, `d_req` and `if_req` held high continuously -> grant order is data, data, fetch, data, data, fetch. Guard off -> fetch is never acked.
- Reset pulsed during WAIT -> `mem_en`=0 and all outputs 0 immediately; no ack for the aborted access; a fresh request after release completes normally.
- `MEM_LATENCY`=15 -> ack exactly 17 cycles after the sampling edge; `stall` high throughout.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory buses of the unified-memory arbiter.
// slave is the arbiter's view; master is the view of the core and memory that surround it.
interface mem_arbiter_if #(parameter int WIDTH = 32);
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic [WIDTH-1:0] if_rdata;
    logic             if_ack;
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_ack;
    logic             stall;
    logic             mem_en;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, stall, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, stall, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between instruction fetch and data access.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic             owner_d;
    logic             owner_we;
    logic [3:0]       lat;
    logic             grant_d;
    logic             start;
    logic [WIDTH-1:0] addr_nx;
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
        $error("mem_arbiter: MEM_LATENCY and STARVE_LIMIT must be within 1..15");
    end
    assign start   = (state == IDLE) && (bus.if_req || bus.d_req);
    assign addr_nx = grant_d ? bus.d_addr : bus.if_addr;
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    assign grant_d = bus.d_req && !(bus.if_req && starve_cnt == 4'(STARVE_LIMIT));
    // Only data grants that left a fetch waiting count toward starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (start)
            starve_cnt <= (grant_d && bus.if_req) ? starve_cnt + 4'd1 : '0;
    end
`else
    assign grant_d = bus.d_req;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = start ? ISSUE : IDLE;
            ISSUE: state_nx = WAIT;
            WAIT:  state_nx = (lat == 4'd1) ? DONE : WAIT;
            DONE:  state_nx = IDLE;
        endcase
    end
    // mem_en/mem_we are registered at the grant edge so they are high for the ISSUE cycle only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_d       <= 1'b0;
            owner_we      <= 1'b0;
            lat           <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
        end else begin
            bus.mem_en <= start;
            bus.mem_we <= start && grant_d && bus.d_we;
            if (start) begin
                owner_d      <= grant_d;
                owner_we     <= grant_d && bus.d_we;
                bus.mem_addr <= addr_nx;
                if (grant_d)
                    bus.mem_wdata <= bus.d_wdata;
            end
            if (state == ISSUE)
                lat <= 4'(MEM_LATENCY);
            if (state == WAIT)
                lat <= lat - 4'd1;
            if (state == WAIT && lat == 4'd1 && !owner_we) begin
                if (owner_d)
                    bus.d_rdata <= bus.mem_rdata;
                else
                    bus.if_rdata <= bus.mem_rdata;
            end
        end
    end
    assign bus.if_ack = (state == DONE) && !owner_d;
    assign bus.d_ack  = (state == DONE) && owner_d;
    assign bus.stall  = (bus.if_req && !bus.if_ack) || (bus.d_req && !bus.d_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (latency 2 and latency 15 instances).
// Expected grant order under contention follows MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.WIDTH(32)) bus ();
    mem_arbiter_if #(.WIDTH(32)) b15 ();
    mem_arbiter #(.WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    mem_arbiter #(.WIDTH(32), .MEM_LATENCY(15), .STARVE_LIMIT(4)) dut15 (.clk(clk), .reset(reset), .bus(b15));

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C02_0004 : (a ^ 32'hA5A5_0000) + 32'h11;
    endfunction

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    // Fixed-latency memory: data is valid only in the cycle MEM_LATENCY after the strobe.
    logic [3:0]  pc1 = 0, pc15 = 0;
    logic [31:0] pa1 = 0, pa15 = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = 0, wr_data = 0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            pa1 <= bus.mem_addr;
            pc1 <= 4'd2;
        end else if (pc1 != 0) pc1 <= pc1 - 4'd1;
        if (bus.mem_en && bus.mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
        end
        if (b15.mem_en) begin
            pa15 <= b15.mem_addr;
            pc15 <= 4'd15;
        end else if (pc15 != 0) pc15 <= pc15 - 4'd1;
    end
    assign bus.mem_rdata = (pc1 == 4'd1) ? mem_val(pa1) : 32'hBAD0_BAD0;
    assign b15.mem_rdata = (pc15 == 4'd1) ? mem_val(pa15) : 32'hBAD0_BAD0;

    typedef struct {
        bit          is_d;
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (!reset && (bus.if_ack || bus.d_ack)) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'(bus.if_ack | bus.d_ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", 32'(bus.d_ack), 32'(e.is_d));
                chk("ack_onehot", 32'(bus.if_ack & bus.d_ack), 32'd0);
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("ack_data", e.is_d ? bus.d_rdata : bus.if_rdata, e.data);
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    int t;
    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        b15.if_req = 0; b15.if_addr = 0; b15.d_req = 0; b15.d_we = 0; b15.d_addr = 0; b15.d_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst15_mem_en", 32'(b15.mem_en), 0);
        reset = 0;
        @(negedge clk);

        // single fetch
        t = cyc;
        bus.if_req = 1; bus.if_addr = 32'h40;
        sb.push_back('{0, t + 4, 32'h8C02_0004});
        #1 chk("fetch_stall_req", 32'(bus.stall), 1);
        goto(t + 1);
        chk("fetch_issue_en", 32'(bus.mem_en), 1);
        chk("fetch_issue_we", 32'(bus.mem_we), 0);
        chk("fetch_issue_addr", bus.mem_addr, 32'h40);
        goto(t + 2);
        chk("fetch_en_one_cycle", 32'(bus.mem_en), 0);
        chk("fetch_stall_wait", 32'(bus.stall), 1);
        goto(t + 4);
        chk("fetch_ack", 32'(bus.if_ack), 1);
        chk("fetch_stall_ack", 32'(bus.stall), 0);
        bus.if_req = 0;
        goto(t + 5);
        chk("fetch_ack_pulse", 32'(bus.if_ack), 0);
        chk("fetch_stall_after", 32'(bus.stall), 0);
        chk("fetch_rdata_hold", bus.if_rdata, 32'h8C02_0004);

        // simultaneous load and fetch: data first
        t = cyc;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        bus.if_req = 1; bus.if_addr = 32'h44;
        sb.push_back('{1, t + 4, mem_val(32'h100)});
        sb.push_back('{0, t + 9, mem_val(32'h44)});
        goto(t + 1);
        chk("both_first_addr", bus.mem_addr, 32'h100);
        goto(t + 4);
        chk("both_d_ack", 32'(bus.d_ack), 1);
        bus.d_req = 0;
        #1 chk("both_stall_fetch_wait", 32'(bus.stall), 1);
        goto(t + 6);
        chk("both_fetch_issue", 32'(bus.mem_en), 1);
        chk("both_fetch_addr", bus.mem_addr, 32'h44);
        goto(t + 9);
        bus.if_req = 0;
        goto(t + 10);

        // store
        t = cyc;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
        sb.push_back('{1, t + 4, mem_val(32'h100)});
        goto(t + 1);
        chk("st_en", 32'(bus.mem_en), 1);
        chk("st_we", 32'(bus.mem_we), 1);
        chk("st_addr", bus.mem_addr, 32'h200);
        chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        goto(t + 2);
        chk("st_en_low", 32'(bus.mem_en), 0);
        chk("st_we_low", 32'(bus.mem_we), 0);
        chk("st_addr_hold", bus.mem_addr, 32'h200);
        chk("st_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
        goto(t + 4);
        bus.d_req = 0; bus.d_we = 0;
        goto(t + 5);
        chk("st_write_count", 32'(wr_cnt), 1);
        chk("st_write_addr", wr_addr, 32'h200);
        chk("st_write_data", wr_data, 32'hDEAD_BEEF);
        chk("st_d_rdata_hold", bus.d_rdata, mem_val(32'h100));

        // sustained contention
        t = cyc;
        bus.d_req = 1; bus.d_addr = 32'h300;
        bus.if_req = 1; bus.if_addr = 32'h48;
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            bit f = (k % 3 == 2);
`else
            bit f = 1'b0;
`endif
            sb.push_back('{!f, t + 4 + 5 * k, f ? mem_val(32'h48) : mem_val(32'h300)});
        end
        goto(t + 12);
        chk("cont_stall", 32'(bus.stall), 1);
        goto(t + 29);
        bus.d_req = 0; bus.if_req = 0;
        goto(t + 30);

        // request withdrawn after sampling still completes
        t = cyc;
        bus.if_req = 1; bus.if_addr = 32'h4C;
        sb.push_back('{0, t + 4, mem_val(32'h4C)});
        goto(t + 1);
        bus.if_req = 0;
        #1 chk("drop_stall_low", 32'(bus.stall), 0);
        chk("drop_issue", 32'(bus.mem_en), 1);
        goto(t + 5);

        // reset during WAIT abandons the access
        t = cyc;
        bus.if_req = 1; bus.if_addr = 32'h50;
        goto(t + 2);
        reset = 1;
        #1;
        chk("abort_mem_en", 32'(bus.mem_en), 0);
        chk("abort_mem_we", 32'(bus.mem_we), 0);
        chk("abort_mem_addr", bus.mem_addr, 0);
        chk("abort_mem_wdata", bus.mem_wdata, 0);
        chk("abort_if_rdata", bus.if_rdata, 0);
        chk("abort_d_rdata", bus.d_rdata, 0);
        chk("abort_acks", {30'd0, bus.if_ack, bus.d_ack}, 0);
        bus.if_req = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        goto(t + 12);
        chk("abort_no_pending", 32'(sb.size()), 0);
        t = cyc;
        bus.d_req = 1; bus.d_addr = 32'h60;
        sb.push_back('{1, t + 4, mem_val(32'h60)});
        goto(t + 4);
        bus.d_req = 0;
        goto(t + 5);
        chk("abort_fresh_rdata", bus.d_rdata, mem_val(32'h60));

        // latency 15
        t = cyc;
        b15.if_req = 1; b15.if_addr = 32'h70;
        goto(t + 1);
        chk("l15_issue", 32'(b15.mem_en), 1);
        for (int k = 1; k <= 16; k++) begin
            goto(t + k);
            chk("l15_stall", 32'(b15.stall), 1);
            chk("l15_no_ack", 32'(b15.if_ack), 0);
        end
        goto(t + 17);
        chk("l15_ack", 32'(b15.if_ack), 1);
        chk("l15_rdata", b15.if_rdata, mem_val(32'h70));
        b15.if_req = 0;
        goto(t + 18);
        chk("l15_ack_pulse", 32'(b15.if_ack), 0);
        chk("l15_stall_after", 32'(b15.stall), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
